// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared core definitions for the 16-bit pipelined core: default
//            address/data widths and the memory-port arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Core-wide bus widths, also used by the fetch and memory-access stages
  localparam int CORE_ADDR_W = 16;
  localparam int CORE_DATA_W = 16;

  // Arbiter states: waiting for a request, or owning memory for one stage
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_MA = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port main memory between instruction fetch
//            (read-only) and memory access (read/write). Registers the winning
//            request, holds the memory handshake until mem_ready, returns read
//            data with a one-cycle valid pulse, and bounds how many data
//            accesses may overtake a waiting fetch.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = CORE_ADDR_W,
  parameter int DATA_W        = CORE_DATA_W,
  parameter int MAX_MA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,

  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic [DATA_W-1:0] ma_rdata,
  output logic              ma_valid,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic              stall_if,
  output logic              stall_ma
);

  localparam int                  STREAK_W     = $clog2(MAX_MA_STREAK + 1);
  localparam logic [STREAK_W-1:0] c_streak_max = STREAK_W'(MAX_MA_STREAK);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;

  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_if_valid;
  logic [DATA_W-1:0]   r_ma_rdata;
  logic                r_ma_valid;
  logic [STREAK_W-1:0] r_streak;

  logic                w_if_elig;
  logic                w_ma_elig;
  logic                w_grant_if;
  logic                w_grant_ma;
  logic                w_done;
  logic                w_streak_full;

  // Fetch is forced through once MA has won this many times while IF waited
  assign w_streak_full = (r_streak == c_streak_max);

  // Next-state and grant decision; a stage in its valid cycle is not eligible
  always_comb begin
    w_if_elig   = if_req & ~r_if_valid;
    w_ma_elig   = ma_req & ~r_ma_valid;
    w_grant_if  = 1'b0;
    w_grant_ma  = 1'b0;
    w_done      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_if_elig && (!w_ma_elig || w_streak_full)) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_BUSY_IF;
        end else if (w_ma_elig) begin
          w_grant_ma  = 1'b1;
          w_state_nxt = ST_BUSY_MA;
        end
      end
      ST_BUSY_IF, ST_BUSY_MA: begin
        if (mem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory handshake, completion pulses, returned data and starvation counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_ma_rdata  <= '0;
      r_ma_valid  <= 1'b0;
      r_streak    <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_ma_valid <= 1'b0;
      if (w_grant_if) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= if_addr;
        r_streak   <= '0;
      end else if (w_grant_ma) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= ma_we;
        r_mem_addr  <= ma_addr;
        r_mem_wdata <= ma_wdata;
        // Only count overtakes that happen while fetch is asking
        if (if_req && !w_streak_full) begin
          r_streak <= r_streak + 1'b1;
        end
      end else if (w_done) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        if (r_state == ST_BUSY_IF) begin
          r_if_valid <= 1'b1;
          r_if_rdata <= mem_rdata;
        end else begin
          r_ma_valid <= 1'b1;
          // A completed write leaves the last read data in place
          if (!r_mem_we) begin
            r_ma_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign ma_rdata  = r_ma_rdata;
  assign ma_valid  = r_ma_valid;

  // Stalls are combinational so a stage freezes in the same cycle it asks
  assign stall_if = if_req & ~r_if_valid;
  assign stall_ma = ma_req & ~r_ma_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: directed scenarios plus
//            a randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int MAX_STREAK = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              ma_req;
  logic              ma_we;
  logic [ADDR_W-1:0] ma_addr;
  logic [DATA_W-1:0] ma_wdata;
  logic [DATA_W-1:0] ma_rdata;
  logic              ma_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_ma;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory contents for the randomized run
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  // Reference model state: who owns memory (0 none, 1 fetch, 2 data)
  int                m_owner;
  int                m_streak;
  logic              e_mem_req, e_mem_we, e_if_valid, e_ma_valid;
  logic [ADDR_W-1:0] e_mem_addr;
  logic [DATA_W-1:0] e_mem_wdata, e_if_rdata, e_ma_rdata;
  logic              p_if_req, p_ma_req, p_ma_we, p_ready;
  logic [ADDR_W-1:0] p_if_addr, p_ma_addr;
  logic [DATA_W-1:0] p_ma_wdata;

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .MAX_MA_STREAK(MAX_STREAK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .ma_req   (ma_req),
    .ma_we    (ma_we),
    .ma_addr  (ma_addr),
    .ma_wdata (ma_wdata),
    .ma_rdata (ma_rdata),
    .ma_valid (ma_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall_if (stall_if),
    .stall_ma (stall_ma)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    ma_req    = 1'b0;
    ma_we     = 1'b0;
    ma_addr   = '0;
    ma_wdata  = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  function automatic logic [DATA_W-1:0] mem_peek(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 16'hC3C3;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    quiet_inputs();
    #2 reset = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_valid, ma_valid, if_rdata, ma_rdata,
         stall_if, stall_ma} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {mem_req, mem_we, mem_addr, mem_wdata, if_valid, ma_valid, if_rdata, ma_rdata});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_if_read();
    if_req  = 1'b1;
    if_addr = 16'h0010;
    #1;
    n_tests++;
    if (stall_if !== 1'b1) begin
      n_fail++; $display("FAIL if_read_stall_c0: got %b want 1", stall_if);
    end
    tick();
    n_tests++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      n_fail++; $display("FAIL if_read_c1: got %h want %h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0010});
    end
    mem_ready = 1'b1;
    mem_rdata = 16'hA5A5;
    tick();
    n_tests++;
    if ({if_valid, if_rdata, mem_req, stall_if} !== {1'b1, 16'hA5A5, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL if_read_c2: got %h want %h", {if_valid, if_rdata, mem_req, stall_if}, {1'b1, 16'hA5A5, 1'b0, 1'b0});
    end
    if_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
    n_tests++;
    if (if_valid !== 1'b0) begin
      n_fail++; $display("FAIL if_read_pulse: got %b want 0", if_valid);
    end
  endtask

  task automatic test_ma_write_wait();
    ma_req    = 1'b1;
    ma_we     = 1'b1;
    ma_addr   = 16'h0200;
    ma_wdata  = 16'h1234;
    mem_rdata = 16'hDEAD;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, stall_ma, ma_valid} !==
          {1'b1, 1'b1, 16'h0200, 16'h1234, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL ma_write_hold[%0d]: got %h want %h", i,
                           {mem_req, mem_we, mem_addr, mem_wdata, stall_ma, ma_valid},
                           {1'b1, 1'b1, 16'h0200, 16'h1234, 1'b1, 1'b0});
      end
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    n_tests++;
    if ({ma_valid, ma_rdata, mem_req, mem_we, stall_ma} !== {1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL ma_write_done: got %h want %h", {ma_valid, ma_rdata, mem_req, mem_we, stall_ma},
                         {1'b1, 16'h0000, 1'b0, 1'b0, 1'b0});
    end
    ma_req    = 1'b0;
    ma_we     = 1'b0;
    mem_ready = 1'b0;
    tick();
    n_tests++;
    if (ma_valid !== 1'b0) begin
      n_fail++; $display("FAIL ma_write_pulse: got %b want 0", ma_valid);
    end
  endtask

  task automatic test_simultaneous();
    if_req  = 1'b1;
    if_addr = 16'h0020;
    ma_req  = 1'b1;
    ma_we   = 1'b0;
    ma_addr = 16'h0300;
    tick();
    n_tests++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0300}) begin
      n_fail++; $display("FAIL simul_first_ma: got %h want %h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0300});
    end
    mem_ready = 1'b1;
    mem_rdata = 16'h3333;
    tick();
    n_tests++;
    if ({ma_valid, ma_rdata, if_valid, stall_if} !== {1'b1, 16'h3333, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL simul_ma_done: got %h want %h", {ma_valid, ma_rdata, if_valid, stall_if}, {1'b1, 16'h3333, 1'b0, 1'b1});
    end
    ma_req    = 1'b0;
    mem_rdata = 16'h4444;
    tick();
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0020}) begin
      n_fail++; $display("FAIL simul_then_if: got %h want %h", {mem_req, mem_addr}, {1'b1, 16'h0020});
    end
    tick();
    n_tests++;
    if ({if_valid, if_rdata, ma_valid} !== {1'b1, 16'h4444, 1'b0}) begin
      n_fail++; $display("FAIL simul_if_done: got %h want %h", {if_valid, if_rdata, ma_valid}, {1'b1, 16'h4444, 1'b0});
    end
    if_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  // Fetch withdraws its request during each valid cycle and re-asserts it the
  // next cycle, so every data grant is taken against a waiting fetch.
  task automatic test_starvation();
    int got[$];
    int want [6] = '{2, 2, 2, 2, 1, 2};
    if_addr   = 16'h0040;
    ma_addr   = 16'h0500;
    ma_we     = 1'b0;
    mem_rdata = 16'h5555;
    mem_ready = 1'b1;
    if_req    = 1'b1;
    ma_req    = 1'b1;
    for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
      tick();
      if (mem_req) got.push_back((mem_addr == 16'h0040) ? 1 : 2);
      if_req = !(if_valid || ma_valid);
    end
    n_tests++;
    if (got.size() != 6) begin
      n_fail++; $display("FAIL starve_grant_count: got %0d want 6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (got[k] != want[k]) begin
          n_fail++; $display("FAIL starve_grant[%0d]: got %0d want %0d (1=IF 2=MA)", k, got[k], want[k]);
        end
      end
    end
    if_req = 1'b0;
    ma_req = 1'b0;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    ma_req  = 1'b1;
    ma_we   = 1'b0;
    ma_addr = 16'h0600;
    tick();
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL areset_busy: got %b want 1", mem_req);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_valid, ma_valid, if_rdata, ma_rdata} !== '0) begin
      n_fail++; $display("FAIL areset_immediate: got %h want 0",
                         {mem_req, mem_we, mem_addr, mem_wdata, if_valid, ma_valid, if_rdata, ma_rdata});
    end
    mem_ready = 1'b1;
    tick();
    n_tests++;
    if ({mem_req, ma_valid} !== 2'b00) begin
      n_fail++; $display("FAIL areset_no_valid: got %b want 00", {mem_req, ma_valid});
    end
    ma_req    = 1'b0;
    mem_ready = 1'b0;
    reset     = 1'b1;
    #1;
    if_req  = 1'b1;
    if_addr = 16'h0070;
    tick();
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0070}) begin
      n_fail++; $display("FAIL areset_fresh_c1: got %h want %h", {mem_req, mem_addr}, {1'b1, 16'h0070});
    end
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    n_tests++;
    if ({if_valid, if_rdata} !== {1'b1, 16'hBEEF}) begin
      n_fail++; $display("FAIL areset_fresh_c2: got %h want %h", {if_valid, if_rdata}, {1'b1, 16'hBEEF});
    end
    if_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_ready_idle();
    mem_ready = 1'b1;
    mem_rdata = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({mem_req, if_valid, ma_valid, if_rdata, ma_rdata} !== {3'b000, 16'hBEEF, 16'h0000}) begin
        n_fail++; $display("FAIL ready_idle[%0d]: got %h want %h", i,
                           {mem_req, if_valid, ma_valid, if_rdata, ma_rdata}, {3'b000, 16'hBEEF, 16'h0000});
      end
    end
    ma_req  = 1'b1;
    ma_we   = 1'b0;
    ma_addr = 16'h0700;
    tick();
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0700}) begin
      n_fail++; $display("FAIL ready_idle_grant: got %h want %h", {mem_req, mem_addr}, {1'b1, 16'h0700});
    end
    tick();
    n_tests++;
    if ({ma_valid, ma_rdata} !== {1'b1, 16'h7777}) begin
      n_fail++; $display("FAIL ready_idle_done: got %h want %h", {ma_valid, ma_rdata}, {1'b1, 16'h7777});
    end
    ma_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  // One model step: apply the rules to last cycle's inputs
  task automatic model_step();
    logic if_el, ma_el, nv_if, nv_ma;
    nv_if = 1'b0;
    nv_ma = 1'b0;
    if (m_owner == 0) begin
      if_el = p_if_req && !e_if_valid;
      ma_el = p_ma_req && !e_ma_valid;
      if (if_el && (!ma_el || m_streak == MAX_STREAK)) begin
        m_owner    = 1;
        e_mem_req  = 1'b1;
        e_mem_we   = 1'b0;
        e_mem_addr = p_if_addr;
        m_streak   = 0;
      end else if (ma_el) begin
        m_owner     = 2;
        e_mem_req   = 1'b1;
        e_mem_we    = p_ma_we;
        e_mem_addr  = p_ma_addr;
        e_mem_wdata = p_ma_wdata;
        if (p_if_req) m_streak = (m_streak + 1 > MAX_STREAK) ? MAX_STREAK : m_streak + 1;
      end
    end else if (p_ready) begin
      if (m_owner == 1) begin
        nv_if      = 1'b1;
        e_if_rdata = mem_peek(e_mem_addr);
      end else begin
        nv_ma = 1'b1;
        if (e_mem_we) ref_mem[e_mem_addr] = e_mem_wdata;
        else          e_ma_rdata = mem_peek(e_mem_addr);
      end
      e_mem_req = 1'b0;
      e_mem_we  = 1'b0;
      m_owner   = 0;
    end
    e_if_valid = nv_if;
    e_ma_valid = nv_ma;
  endtask

  task automatic test_random(input int n_cycles);
    reset = 1'b0;
    quiet_inputs();
    tick();
    reset = 1'b1;
    ref_mem.delete();
    m_owner = 0; m_streak = 0;
    {e_mem_req, e_mem_we, e_if_valid, e_ma_valid} = '0;
    {e_mem_addr, e_mem_wdata, e_if_rdata, e_ma_rdata} = '0;
    {p_if_req, p_ma_req, p_ma_we, p_ready} = '0;
    {p_if_addr, p_ma_addr, p_ma_wdata} = '0;
    for (int c = 0; c < n_cycles; c++) begin
      tick();
      model_step();
      n_tests++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata, ma_valid, ma_rdata} !==
          {e_mem_req, e_mem_we, e_mem_addr, e_mem_wdata, e_if_valid, e_if_rdata, e_ma_valid, e_ma_rdata}) begin
        n_fail++; $display("FAIL random_outputs cycle %0d: got %h want %h", c,
                           {mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata, ma_valid, ma_rdata},
                           {e_mem_req, e_mem_we, e_mem_addr, e_mem_wdata, e_if_valid, e_if_rdata, e_ma_valid, e_ma_rdata});
      end
      // Fetch requester: reissue after completion, occasionally withdraw
      if (if_valid) begin
        if_req  = ($urandom_range(0, 1) == 1);
        if_addr = {12'h000, 4'($urandom)};
      end else if (if_req && $urandom_range(0, 7) == 0) begin
        if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = {12'h000, 4'($urandom)};
      end
      // Data requester: same pattern with random direction and data
      if (ma_valid || (!ma_req && $urandom_range(0, 1) == 0)) begin
        ma_req   = ($urandom_range(0, 3) != 0);
        ma_we    = $urandom_range(0, 1) == 1;
        ma_addr  = {12'h000, 4'($urandom)};
        ma_wdata = 16'($urandom);
      end else if (ma_req && $urandom_range(0, 11) == 0) begin
        ma_req = 1'b0;
      end
      mem_ready = ($urandom_range(0, 1) == 1);
      mem_rdata = mem_req ? mem_peek(mem_addr) : 16'($urandom);
      #1;
      n_tests++;
      if ({stall_if, stall_ma} !== {if_req & ~e_if_valid, ma_req & ~e_ma_valid}) begin
        n_fail++; $display("FAIL random_stall cycle %0d: got %b want %b", c, {stall_if, stall_ma},
                           {if_req & ~e_if_valid, ma_req & ~e_ma_valid});
      end
      p_if_req = if_req; p_if_addr = if_addr;
      p_ma_req = ma_req; p_ma_we = ma_we; p_ma_addr = ma_addr; p_ma_wdata = ma_wdata;
      p_ready  = mem_ready;
    end
    quiet_inputs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_ma_write_wait();
    test_simultaneous();
    test_starvation();
    test_async_reset();
    test_ready_idle();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
